// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes the immediate, format code and illegal-opcode flag of a 32-bit instruction and registers them with its tag.
// Latency: 1 cycle from input transfer to out_valid; sustains 1 instruction/cycle while out_ready is high.
// Backpressure: outputs hold while stalled. IMMGEN_SKID_EN adds a one-entry skid buffer so in_ready comes from a flop; otherwise in_ready = out_ready || !out_valid.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_SH  = 3'd6;
    localparam logic [2:0] FMT_UNK = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t               dec_res;
    logic signed [31:0] dec_se32;
    logic [2:0]         dec_fmt;
    logic               dec_ill;

    res_t               out_q;
    res_t               out_d;
    logic               out_valid_q;
    logic               out_valid_d;
    logic               take;

    // Decode the immediate as a 32-bit signed value; widening to XLEN sign-extends from inst[31].
    always_comb begin
        dec_se32 = '0;
        dec_fmt  = FMT_UNK;
        dec_ill  = 1'b0;
        unique case (in_inst[6:0])
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                dec_se32 = {{20{in_inst[31]}}, in_inst[31:20]};
                dec_fmt  = FMT_I;
            end
            OP_IMM: begin
                if (in_inst[13:12] == 2'b01) begin
                    // funct3 001/101: shift amount only, funct7 stays out of the immediate
                    if (XLEN == 64) begin
                        dec_se32 = {26'd0, in_inst[25:20]};
                    end else begin
                        dec_se32 = {27'd0, in_inst[24:20]};
                    end
                    dec_fmt = FMT_SH;
                end else begin
                    dec_se32 = {{20{in_inst[31]}}, in_inst[31:20]};
                    dec_fmt  = FMT_I;
                end
            end
            OP_STORE: begin
                dec_se32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                dec_fmt  = FMT_S;
            end
            OP_BRANCH: begin
                dec_se32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                dec_fmt  = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                dec_se32 = {in_inst[31:12], 12'd0};
                dec_fmt  = FMT_U;
            end
            OP_JAL: begin
                dec_se32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
                dec_fmt  = FMT_J;
            end
            OP_REG: begin
                dec_se32 = '0;
                dec_fmt  = FMT_R;
            end
            default: begin
                dec_se32 = '0;
                dec_fmt  = FMT_UNK;
                dec_ill  = 1'b1;
            end
        endcase
    end

    // Pack the decoded fields with the incoming tag.
    always_comb begin
        dec_res     = '0;
        dec_res.imm = XLEN'(dec_se32);
        dec_res.fmt = dec_fmt;
        dec_res.ill = dec_ill;
        dec_res.tag = in_tag;
    end

`ifdef IMMGEN_SKID_EN
    res_t skid_q;
    res_t skid_d;
    logic skid_valid_q;
    logic skid_valid_d;
    logic consume;

    // in_ready is a pure flop output; the skid entry absorbs the one accept that races a stall.
    assign in_ready = !skid_valid_q;
    assign take     = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    // Next-state: flush wins, then refill the output from skid or input, else park input in skid.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (take) begin
                out_d       = dec_res;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (take) begin
            skid_d       = dec_res;
            skid_valid_d = 1'b1;
        end
    end

    // Skid storage; reset empties it so nothing held before reset reappears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    // Without a skid entry the stage can accept only when its output slot frees this cycle.
    assign in_ready = out_ready || !out_valid_q;
    assign take     = in_valid && in_ready;

    // Next-state: flush wins, then load on accept, else drop valid once consumed.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (take) begin
            out_d       = dec_res;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // Output register; payload only changes when a new result is loaded, so it holds during stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.ill;
    assign out_tag     = out_q.tag;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, handshaked immediate generator for the decode stage. It accepts one 32-bit instruction per cycle and emits the sign-extended immediate at XLEN width, a format code and an illegal-opcode flag one cycle later. It covers all RV32I/RV64I immediate formats (I, S, B, U, J, plus shift-amount immediates) and carries an opaque tag alongside each instruction. Backpressure from the downstream stage is honoured without dropping or duplicating instructions.

## Interface
- `XLEN`, 32 — output immediate width; legal values 32 and 64.
- `TAG_W`, 32 — width of the sideband tag (PC or ROB id) carried with each instruction.
- `clk`  input  1  — single clock, rising edge.
- `rst_n`  input  1  — asynchronous, active-low reset.
- `flush`  input  1  — synchronous pipeline kill.
- `in_valid`  input  1  — an instruction is offered on `in_inst`.
- `in_ready`  output  1  — the block can accept an instruction this cycle.
- `in_inst`  input  32  — raw instruction word.
- `in_tag`  input  TAG_W  — sideband tag.
- `out_valid`  output  1  — result valid.
- `out_ready`  input  1  — downstream accepts the result.
- `out_imm`  output  XLEN  — generated immediate.
- `out_fmt`  output  3  — format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 I-shift, 7 unknown.
- `out_illegal`  output  1  — opcode not recognised.
- `out_tag`  output  TAG_W  — tag of the result.

## Operation
- Opcode `inst[6:0]` decode:
  - 0000011, 0010011, 1100111, 1110011 → I: `inst[31:20]` sign-extended.
  - 0100011 → S: `{inst[31:25], inst[11:7]}` sign-extended.
  - 1100011 → B: `{inst[31], inst[7], inst[30:25], inst[11:8], 0}` sign-extended.
  - 0110111, 0010111 → U: `{inst[31:12], 12'b0}`, sign-extended from bit 31 when XLEN=64.
  - 1101111 → J: `{inst[31], inst[19:12], inst[20], inst[30:21], 0}` sign-extended.
  - 0110011 → R: imm 0.
  - Any other opcode → imm 0, fmt 7, `out_illegal`=1.
- Opcode 0010011 with funct3 001 or 101 → fmt 6. The immediate is the shift amount, zero-extended: `inst[24:20]` when XLEN=32, `inst[25:20]` when XLEN=64. funct7 bits are not part of the immediate.
- All sign extension uses `inst[31]` and fills to XLEN.
- A transfer occurs when `in_valid && in_ready`. The decoded result and the tag are registered.
- An output is consumed when `out_valid && out_ready`.
- While `out_valid && !out_ready`, all `out_*` signals hold stable.

## Timing
- Latency is 1 cycle from input transfer to `out_valid`. Sustained throughput is 1 instruction per cycle while `out_ready`=1.
- Reset values: `out_valid`=0, `out_imm`=0, `out_fmt`=0, `out_illegal`=0, `out_tag`=0, `in_ready`=1.
- Reset asserted mid-stall discards every held entry immediately. No result is emitted after release.
- Flush:
  - `flush`=1 clears `out_valid` and any skid entry at the next edge.
  - An input transferred in the flush cycle is discarded.
  - `flush` takes priority over every simultaneous transfer.
- Simultaneous input transfer and output consume in the same cycle: the new result replaces the old one with no bubble.
- No instruction is lost, duplicated or reordered under any `out_ready` pattern.

## Configuration
- `IMMGEN_SKID_EN` defined:
  - Adds a one-entry skid buffer.
  - `in_ready` is driven directly from a flop (`!skid_valid`), so there is no combinational path from `out_ready` to `in_ready`.
  - An input accepted while the output is stalled goes into the skid buffer. The skid entry moves to the output on the next consume.
  - `in_ready` drops the cycle after the skid buffer fills.
- `IMMGEN_SKID_EN` undefined:
  - No skid buffer.
  - `in_ready = out_ready || !out_valid`, a combinational path.
- Per-instruction behaviour and latency are identical in both builds.

## Test plan
- XLEN=32, `0xFFC12083` (lw, -4) → `out_imm`=0xFFFFFFFC, fmt 1. Then `0x00512423` (sw, 8) → 0x00000008, fmt 2. Both with `out_ready`=1, back-to-back, one cycle apart.
- Branch/jump: `0xFE000CE3` (beq, -8) → 0xFFFFFFF8, fmt 3. `0xFFDFF06F` (jal, -4) → 0xFFFFFFFC, fmt 5.
- U and shift: `0x123450B7` (lui) → 0x12345000, fmt 4. `0x4030D093` (srai, 3) → 0x00000003, fmt 6. XLEN=64 lui with `inst[31]`=1 → upper 32 bits all ones.
- Illegal: `0x0000007F` → imm 0, fmt 7, `out_illegal`=1. The tag is passed through unchanged.
- Backpressure: stream 8 tagged instructions with `out_ready` toggling pseudo-randomly → all 8 tags out in order, no duplicates. Outputs stay stable during stalls. With `IMMGEN_SKID_EN`, `in_ready` never depends combinationally on `out_ready`.
- Flush with valid output and full skid, concurrent with `in_valid` → `out_valid`=0 next cycle and none of the three instructions ever appears. Async `rst_n` pulse mid-stall → all outputs return to reset values immediately.
